// File: rtl/spart_pkg.sv
// Shared types and constants for the SPART bring-up bus master.
package spart_pkg;

  typedef enum logic [2:0] {
    CFG_LO,
    CFG_HI,
    IDLE,
    RD,
    WR,
    SETTLE
  } state_t;

  typedef logic [1:0] ioaddr_t;

  localparam ioaddr_t ADDR_BUF  = 2'b00;
  localparam ioaddr_t ADDR_STAT = 2'b01;
  localparam ioaddr_t ADDR_DBL  = 2'b10;
  localparam ioaddr_t ADDR_DBH  = 2'b11;

  // Rounded 16x-oversampling divisor: (f + 8*baud)/(16*baud) - 1.
  // Only ever called with constant arguments, so it folds away at elaboration.
  function automatic logic [15:0] calc_div(input logic [31:0] clk_freq,
                                           input logic [31:0] baud);
    logic [31:0] q;
    q = (clk_freq + 32'd8 * baud) / (32'd16 * baud) - 32'd1;
    return q[15:0];
  endfunction

endpackage

// File: rtl/spart_driver_if.sv
// Processor-side SPART control/handshake signals (the data bus stays a top-level inout).
interface spart_driver_if;
  import spart_pkg::*;

  logic    iocs;
  logic    iorw;
  ioaddr_t ioaddr;
  logic    rda;
  logic    tbr;

  modport master (output iocs, iorw, ioaddr, input rda, tbr);
  modport slave  (input iocs, iorw, ioaddr, output rda, tbr);
endinterface

// File: rtl/spart_echo_fifo.sv
// Small synchronous FIFO buffering received bytes until the transmitter is ready.
// DEPTH must be a power of two (>= 2) so the pointers wrap naturally.
module spart_echo_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push;
  logic             do_pop;

  assign full    = (count_q == DEPTH_C);
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rdata   = mem[rd_ptr_q];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Next-state for pointers and occupancy; pointers wrap modulo DEPTH.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    if (do_push && !do_pop) begin
      count_d = count_q + 1'b1;
    end else if (do_pop && !do_push) begin
      count_d = count_q - 1'b1;
    end
  end

  // Pointer/occupancy registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents need no reset since occupancy gates every read.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_q] <= wdata;
    end
  end

endmodule

// File: rtl/spart_driver.sv
// Bus master standing in for a CPU: programs the SPART baud divisor, then
// echoes every received byte back to the transmitter through a small FIFO.
// All bus outputs are registered on entry to an access state, so each access
// state is exactly the one-cycle iocs pulse, always followed by SETTLE.
module spart_driver
  import spart_pkg::*;
#(
  parameter int unsigned CLK_FREQ   = 50000000,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [1:0]                    br_cfg,
  spart_driver_if.master                bus,
  inout  wire  [7:0]                    databus,
  output logic [7:0]                    rx_byte,
  output logic                          rx_strobe,
  output logic                          cfg_done,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  // Divisor per br_cfg code: code n selects 4800 * 2^n baud.
  logic [15:0] div_tab [4];
  for (genvar gi = 0; gi < 4; gi++) begin : g_div
    assign div_tab[gi] = calc_div(CLK_FREQ, 32'd4800 << gi);
  end

  state_t      state_q, state_d;
  state_t      ret_q, ret_d;
  logic        iocs_q, iocs_d;
  logic        iorw_q, iorw_d;
  ioaddr_t     ioaddr_q, ioaddr_d;
  logic        oe_q, oe_d;
  logic [7:0]  dout_q, dout_d;
  logic [1:0]  cfg_q, cfg_d;
  logic        cfg_done_q, cfg_done_d;
  logic [7:0]  rx_byte_q, rx_byte_d;
  logic        rx_strobe_q, rx_strobe_d;

  logic        push;
  logic        pop;
  logic        fifo_full;
  logic        fifo_empty;
  logic [7:0]  fifo_head;
  logic [15:0] div_new;
  logic [15:0] div_cur;

  assign div_new = div_tab[br_cfg];
  assign div_cur = div_tab[cfg_q];

  spart_echo_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .wdata (databus),
    .rdata (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // The bus is only ever driven during a write access; reads leave it to the SPART.
  assign databus    = oe_q ? dout_q : 8'hzz;
  assign bus.iocs   = iocs_q;
  assign bus.iorw   = iorw_q;
  assign bus.ioaddr = ioaddr_q;
  assign rx_byte    = rx_byte_q;
  assign rx_strobe  = rx_strobe_q;
  assign cfg_done   = cfg_done_q;

  // Sequencer: decides the next access and precomputes its registered bus outputs.
  always_comb begin
    state_d     = state_q;
    ret_d       = ret_q;
    iocs_d      = 1'b0;
    iorw_d      = 1'b1;
    ioaddr_d    = ioaddr_q;
    oe_d        = 1'b0;
    dout_d      = dout_q;
    cfg_d       = cfg_q;
    cfg_done_d  = cfg_done_q;
    rx_byte_d   = rx_byte_q;
    rx_strobe_d = 1'b0;
    push        = 1'b0;
    pop         = 1'b0;

    unique case (state_q)
      CFG_LO: begin
        if (iocs_q) begin
          // Low-byte write is on the bus this cycle.
          state_d = SETTLE;
          ret_d   = CFG_HI;
        end else begin
          // First cycle out of reset: nothing is on the bus yet, so launch the write.
          iocs_d   = 1'b1;
          iorw_d   = 1'b0;
          ioaddr_d = ADDR_DBL;
          oe_d     = 1'b1;
          dout_d   = div_new[7:0];
          cfg_d    = br_cfg;
        end
      end

      CFG_HI: begin
        state_d = SETTLE;
        ret_d   = IDLE;
      end

      SETTLE: begin
        state_d = ret_q;
        if (ret_q == CFG_HI) begin
          iocs_d   = 1'b1;
          iorw_d   = 1'b0;
          ioaddr_d = ADDR_DBH;
          oe_d     = 1'b1;
          dout_d   = div_cur[15:8];
        end else if (ioaddr_q == ADDR_DBH) begin
          // Returning to IDLE straight after the high-byte write: divisor complete.
          cfg_done_d = 1'b1;
        end
      end

      IDLE: begin
        if (br_cfg != cfg_q) begin
          cfg_done_d = 1'b0;
          state_d    = CFG_LO;
          iocs_d     = 1'b1;
          iorw_d     = 1'b0;
          ioaddr_d   = ADDR_DBL;
          oe_d       = 1'b1;
          dout_d     = div_new[7:0];
          cfg_d      = br_cfg;
        end else if (bus.rda && !fifo_full) begin
          state_d  = RD;
          iocs_d   = 1'b1;
          iorw_d   = 1'b1;
          ioaddr_d = ADDR_BUF;
        end else if (bus.tbr && !fifo_empty) begin
          state_d  = WR;
          iocs_d   = 1'b1;
          iorw_d   = 1'b0;
          ioaddr_d = ADDR_BUF;
          oe_d     = 1'b1;
          dout_d   = fifo_head;
        end
      end

      RD: begin
        push        = 1'b1;
        rx_byte_d   = databus;
        rx_strobe_d = 1'b1;
        state_d     = SETTLE;
        ret_d       = IDLE;
      end

      WR: begin
        pop     = 1'b1;
        state_d = SETTLE;
        ret_d   = IDLE;
      end

      default: begin
        state_d = CFG_LO;
      end
    endcase
  end

  // State and registered bus outputs; reset drops iocs and the bus enable at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= CFG_LO;
      ret_q       <= IDLE;
      iocs_q      <= 1'b0;
      iorw_q      <= 1'b1;
      ioaddr_q    <= ADDR_BUF;
      oe_q        <= 1'b0;
      dout_q      <= 8'h00;
      cfg_q       <= 2'b00;
      cfg_done_q  <= 1'b0;
      rx_byte_q   <= 8'h00;
      rx_strobe_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ret_q       <= ret_d;
      iocs_q      <= iocs_d;
      iorw_q      <= iorw_d;
      ioaddr_q    <= ioaddr_d;
      oe_q        <= oe_d;
      dout_q      <= dout_d;
      cfg_q       <= cfg_d;
      cfg_done_q  <= cfg_done_d;
      rx_byte_q   <= rx_byte_d;
      rx_strobe_q <= rx_strobe_d;
    end
  end

endmodule

// File: tb/tb_spart_driver.sv
// Directed bench for spart_driver with a small SPART bus model and access log.
module tb_spart_driver;

  logic       clk;
  logic       rst;
  logic [1:0] br_cfg;
  wire  [7:0] databus;
  logic [7:0] rx_byte;
  logic       rx_strobe;
  logic       cfg_done;
  logic [2:0] fifo_count;

  spart_driver_if bus ();

  spart_driver #(
    .CLK_FREQ   (50000000),
    .FIFO_DEPTH (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .br_cfg     (br_cfg),
    .bus        (bus),
    .databus    (databus),
    .rx_byte    (rx_byte),
    .rx_strobe  (rx_strobe),
    .cfg_done   (cfg_done),
    .fifo_count (fifo_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // SPART receive side: bytes offered by the stimulus, consumed by reads.
  logic [7:0] rx_mem [16];
  int         rx_wr = 0;
  int         rx_rd = 0;
  logic [7:0] spart_rx;

  assign spart_rx = rx_mem[rx_rd[3:0]];
  assign bus.rda  = (rx_rd != rx_wr);
  assign databus  = (bus.iocs && bus.iorw && bus.ioaddr == 2'b00) ? spart_rx : 8'hzz;

  // Access log: {is_write, addr, data} plus the cycle it happened on.
  logic [10:0] ev [128];
  int          ev_cyc [128];
  int          evcnt = 0;
  int          cyc = 0;
  int          burst_err = 0;
  logic        iocs_prev = 1'b0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bus.iocs) begin
      ev[evcnt[6:0]]     <= {~bus.iorw, bus.ioaddr, databus};
      ev_cyc[evcnt[6:0]] <= cyc;
      evcnt              <= evcnt + 1;
      if (iocs_prev) burst_err <= burst_err + 1;
      if (bus.iorw && bus.ioaddr == 2'b00 && rx_rd != rx_wr) rx_rd <= rx_rd + 1;
    end
    iocs_prev <= bus.iocs;
  end

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [10:0] ev_at(input int k);
    return ev[k[6:0]];
  endfunction

  function automatic int cyc_at(input int k);
    return ev_cyc[k[6:0]];
  endfunction

  task automatic offer(input logic [7:0] b);
    rx_mem[rx_wr[3:0]] = b;
    rx_wr++;
  endtask

  task automatic wait_ev(input int target, input int limit, input string tag);
    int n = 0;
    while (evcnt < target && n < limit) begin
      @(negedge clk);
      n++;
    end
    check(tag, 32'(evcnt >= target), 32'd1);
  endtask

  task automatic wait_cfg(input logic val, input int limit, input string tag);
    int n = 0;
    while (cfg_done !== val && n < limit) begin
      @(negedge clk);
      n++;
    end
    check(tag, 32'(cfg_done), 32'(val));
  endtask

  task automatic wait_access(input logic is_read, input int limit, input string tag);
    int n = 0;
    while (!(bus.iocs === 1'b1 && bus.iorw === is_read) && n < limit) begin
      @(negedge clk);
      n++;
    end
    check(tag, 32'(bus.iocs && (bus.iorw == is_read)), 32'd1);
  endtask

  logic [10:0] exp3 [6];
  int base;

  initial begin
    rst     = 1'b1;
    br_cfg  = 2'b01;
    bus.tbr = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state
    check("rst_iocs", 32'(bus.iocs), 32'd0);
    check("rst_iorw", 32'(bus.iorw), 32'd1);
    check("rst_ioaddr", 32'(bus.ioaddr), 32'd0);
    check("rst_oe", 32'(dut.oe_q), 32'd0);
    check("rst_rx_byte", 32'(rx_byte), 32'd0);
    check("rst_rx_strobe", 32'(rx_strobe), 32'd0);
    check("rst_cfg_done", 32'(cfg_done), 32'd0);
    check("rst_fifo_count", 32'(fifo_count), 32'd0);
    $display("reset: iocs=%0b iorw=%0b fifo_count=%0d", bus.iocs, bus.iorw, fifo_count);

    // Divisor programming for 9600 baud: 0x0145
    rst = 1'b0;
    wait_cfg(1'b1, 20, "cfg1_done");
    check("cfg1_count", 32'(evcnt), 32'd2);
    check("cfg1_lo", 32'(ev_at(0)), 32'({1'b1, 2'b10, 8'h45}));
    check("cfg1_hi", 32'(ev_at(1)), 32'({1'b1, 2'b11, 8'h01}));
    check("cfg1_gap", 32'(cyc_at(1) - cyc_at(0)), 32'd2);
    check("cfg1_oe_idle", 32'(dut.oe_q), 32'd0);
    $display("cfg 9600: lo=%03h hi=%03h", ev_at(0), ev_at(1));

    // Single echo of 0x5A
    base    = evcnt;
    bus.tbr = 1'b1;
    offer(8'h5A);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    check("echo_strobe", 32'(rx_strobe), 32'd1);
    check("echo_rx_byte", 32'(rx_byte), 32'h5A);
    check("echo_count1", 32'(fifo_count), 32'd1);
    @(negedge clk);
    check("echo_strobe_pulse", 32'(rx_strobe), 32'd0);
    wait_ev(base + 2, 20, "echo_wait");
    check("echo_rd", 32'(ev_at(base)), 32'({1'b0, 2'b00, 8'h5A}));
    check("echo_wr", 32'(ev_at(base + 1)), 32'({1'b1, 2'b00, 8'h5A}));
    check("echo_count0", 32'(fifo_count), 32'd0);
    $display("echo: rd=%03h wr=%03h", ev_at(base), ev_at(base + 1));

    // Fill FIFO with tbr low: fifth byte must stay pending in the SPART
    bus.tbr = 1'b0;
    base    = evcnt;
    for (int i = 1; i <= 5; i++) offer(8'(i));
    wait_ev(base + 4, 40, "fill_wait");
    repeat (6) @(negedge clk);
    check("fill_no_5th_read", 32'(evcnt), 32'(base + 4));
    check("fill_count", 32'(fifo_count), 32'd4);
    check("fill_pending", 32'(rx_wr - rx_rd), 32'd1);
    for (int i = 0; i < 4; i++)
      check("fill_rd", 32'(ev_at(base + i)), 32'({1'b0, 2'b00, 8'(i + 1)}));
    $display("fill: fifo_count=%0d pending=%0d", fifo_count, rx_wr - rx_rd);

    // Drain: first pop frees a slot, so the pending read wins before later writes
    exp3[0] = {1'b1, 2'b00, 8'h01};
    exp3[1] = {1'b0, 2'b00, 8'h05};
    exp3[2] = {1'b1, 2'b00, 8'h02};
    exp3[3] = {1'b1, 2'b00, 8'h03};
    exp3[4] = {1'b1, 2'b00, 8'h04};
    exp3[5] = {1'b1, 2'b00, 8'h05};
    bus.tbr = 1'b1;
    wait_ev(base + 10, 80, "drain_wait");
    for (int i = 0; i < 6; i++)
      check("drain_seq", 32'(ev_at(base + 4 + i)), 32'(exp3[i]));
    check("drain_count", 32'(fifo_count), 32'd0);
    $display("drain: %0d accesses, fifo_count=%0d", evcnt - base, fifo_count);

    // br_cfg 01 -> 11 in the middle of a read with a byte buffered
    bus.tbr = 1'b0;
    base    = evcnt;
    offer(8'h77);
    wait_access(1'b1, 10, "recfg_rd_seen");
    br_cfg = 2'b11;
    check("recfg_done_held", 32'(cfg_done), 32'd1);
    wait_ev(base + 1, 10, "recfg_rd_wait");
    check("recfg_rd", 32'(ev_at(base)), 32'({1'b0, 2'b00, 8'h77}));
    wait_cfg(1'b0, 10, "recfg_done_low");
    check("recfg_count_kept", 32'(fifo_count), 32'd1);
    wait_cfg(1'b1, 20, "recfg_done_high");
    check("recfg_lo", 32'(ev_at(base + 1)), 32'({1'b1, 2'b10, 8'h50}));
    check("recfg_hi", 32'(ev_at(base + 2)), 32'({1'b1, 2'b11, 8'h00}));
    bus.tbr = 1'b1;
    wait_ev(base + 4, 20, "recfg_echo_wait");
    check("recfg_echo", 32'(ev_at(base + 3)), 32'({1'b1, 2'b00, 8'h77}));
    $display("recfg 38400: lo=%03h hi=%03h echo=%03h", ev_at(base + 1), ev_at(base + 2), ev_at(base + 3));

    // rda and tbr together with one byte buffered: read goes first
    bus.tbr = 1'b0;
    base    = evcnt;
    offer(8'h33);
    wait_ev(base + 1, 10, "prio_fill_wait");
    repeat (4) @(negedge clk);
    check("prio_count1", 32'(fifo_count), 32'd1);
    offer(8'h44);
    bus.tbr = 1'b1;
    wait_ev(base + 4, 30, "prio_wait");
    check("prio_rd_first", 32'(ev_at(base + 1)), 32'({1'b0, 2'b00, 8'h44}));
    check("prio_wr_33", 32'(ev_at(base + 2)), 32'({1'b1, 2'b00, 8'h33}));
    check("prio_wr_44", 32'(ev_at(base + 3)), 32'({1'b1, 2'b00, 8'h44}));
    check("prio_rd_to_wr", 32'(cyc_at(base + 2) - cyc_at(base + 1)), 32'd3);
    check("prio_rx_byte", 32'(rx_byte), 32'h44);
    $display("prio: %03h %03h %03h", ev_at(base + 1), ev_at(base + 2), ev_at(base + 3));

    // Reset asserted during a write
    bus.tbr = 1'b0;
    base    = evcnt;
    offer(8'h99);
    wait_ev(base + 1, 10, "rstwr_fill_wait");
    bus.tbr = 1'b1;
    wait_access(1'b0, 10, "rstwr_wr_seen");
    check("rstwr_bus_data", 32'(databus), 32'h99);
    rst = 1'b1;
    #1;
    check("rstwr_iocs", 32'(bus.iocs), 32'd0);
    check("rstwr_oe", 32'(dut.oe_q), 32'd0);
    check("rstwr_iorw", 32'(bus.iorw), 32'd1);
    check("rstwr_ioaddr", 32'(bus.ioaddr), 32'd0);
    check("rstwr_cfg_done", 32'(cfg_done), 32'd0);
    check("rstwr_rx_byte", 32'(rx_byte), 32'd0);
    check("rstwr_count", 32'(fifo_count), 32'd0);
    base = evcnt;
    @(negedge clk);
    check("rstwr_no_commit", 32'(evcnt), 32'(base));
    br_cfg = 2'b10;
    @(negedge clk);
    rst = 1'b0;
    wait_cfg(1'b1, 20, "rstwr_cfg_done");
    check("rstwr_lo", 32'(ev_at(base)), 32'({1'b1, 2'b10, 8'hA2}));
    check("rstwr_hi", 32'(ev_at(base + 1)), 32'({1'b1, 2'b11, 8'h00}));
    repeat (10) @(negedge clk);
    check("rstwr_quiet", 32'(evcnt), 32'(base + 2));
    check("burst_free", 32'(burst_err), 32'd0);
    $display("rst-in-wr: reprogram lo=%03h hi=%03h", ev_at(base), ev_at(base + 1));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
